// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute sequencer with tick-gated run/slow/step/pause modes and a return stack.
// Optional macro CPU_SEQ_RETIRE_CNT_EN enables the 32-bit retired-instruction counter.
module cpu_sequencer #(
  parameter int ADDR_W         = 8,
  parameter int INSTR_W        = 24,
  parameter int STACK_DEPTH    = 4,
  parameter int SLOW_BASE_LOG2 = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [2:0]         speed_sel,
  input  logic               step_btn,
  input  logic               halt_in,
  input  logic               branch_taken,
  input  logic               call,
  input  logic               ret,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic               exec_en,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               fault,
  output logic [31:0]        retired_count
);

  localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int DIV_W = SLOW_BASE_LOG2 + 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_HALT
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_W-1:0]     pc_reg, pc_next, pc_plus1;
  logic [INSTR_W-1:0]    ir_reg;
  logic                  fault_reg, fault_next, fault_now;
  logic [SP_W-1:0]       sp_reg, sp_next;
  logic [SP_W-2:0]       top_idx;
  logic                  push, stack_empty, stack_full;
  logic [STACK_DEPTH-1:0][ADDR_W-1:0] stack_flat;
  logic [ADDR_W-1:0]     stack_top;

  logic [DIV_W-1:0]      div_reg, div_limit;
  logic                  slow_tick;
  logic [1:0]            step_sync_reg;
  logic                  step_prev_reg, step_tick;
  logic                  tick;

  // ---------------- tick generation ----------------
  always_comb begin
    div_limit = ({{(DIV_W-1){1'b0}}, 1'b1} << (SLOW_BASE_LOG2 + int'(speed_sel))) - {{(DIV_W-1){1'b0}}, 1'b1};
  end

  // >= rather than == so a speed_sel decrease mid-count still wraps promptly
  assign slow_tick = (div_reg >= div_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
    end else if (slow_tick) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_reg + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_sync_reg <= 2'b00;
      step_prev_reg <= 1'b0;
    end else begin
      step_sync_reg <= {step_sync_reg[0], step_btn};
      step_prev_reg <= step_sync_reg[1];
    end
  end

  assign step_tick = step_sync_reg[1] & ~step_prev_reg;

  always_comb begin
    tick = 1'b0;
    case (mode)
      2'b00:   tick = 1'b1;
      2'b01:   tick = slow_tick;
      2'b10:   tick = step_tick;
      default: tick = 1'b0;
    endcase
  end

  // ---------------- return stack ----------------
  assign stack_empty = (sp_reg == '0);
  assign stack_full  = (sp_reg == SP_W'(STACK_DEPTH));
  assign top_idx     = sp_reg[SP_W-2:0] - (SP_W-1)'(1);
  assign stack_top   = stack_flat[top_idx];
  assign pc_plus1    = pc_reg + ADDR_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
      logic [ADDR_W-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push && (sp_reg == SP_W'(gi))) begin
          entry_reg <= pc_plus1;
        end
      end
      assign stack_flat[gi] = entry_reg;
    end
  endgenerate

  // ---------------- sequencer FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
      fault_reg <= 1'b0;
      sp_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      fault_reg <= fault_next;
      sp_reg    <= sp_next;
      if (state_reg == S_LATCH) begin
        ir_reg <= imem_data;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    fault_next = fault_reg;
    sp_next    = sp_reg;
    push       = 1'b0;
    fault_now  = 1'b0;
    case (state_reg)
      S_IDLE:  if (tick) state_next = S_FETCH;
      S_FETCH: state_next = S_LATCH;
      S_LATCH: state_next = S_EXEC;
      S_EXEC: begin
        state_next = S_IDLE;
        if (halt_in) begin
          state_next = S_HALT;
        end else if (ret) begin
          if (stack_empty) begin
            fault_now  = 1'b1;
            state_next = S_HALT;
          end else begin
            sp_next = sp_reg - SP_W'(1);
            pc_next = stack_top;
          end
        end else if (call) begin
          if (stack_full) begin
            fault_now  = 1'b1;
            state_next = S_HALT;
          end else begin
            push    = 1'b1;
            sp_next = sp_reg + SP_W'(1);
            pc_next = branch_target;
          end
        end else if (branch_taken) begin
          pc_next = branch_target;
        end else begin
          pc_next = pc_plus1;
        end
        if (fault_now) fault_next = 1'b1;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  assign imem_addr = pc_reg;
  assign pc        = pc_reg;
  assign ir        = ir_reg;
  assign exec_en   = (state_reg == S_EXEC);
  assign halted    = (state_reg == S_HALT);
  assign fault     = fault_reg;

  // ---------------- optional retire counter ----------------
`ifdef CPU_SEQ_RETIRE_CNT_EN
  logic [31:0] retired_reg;
  logic        retire;

  // a faulting EXEC never retires; HALT does
  assign retire = (state_reg == S_EXEC) && !fault_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_reg <= 32'd0;
    end else if (retire) begin
      retired_reg <= retired_reg + 32'd1;
    end
  end

  assign retired_count = retired_reg;
`else
  assign retired_count = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: tiny decoder + synchronous instruction RAM model, hand-computed expectations.
module tb_cpu_sequencer;

  localparam logic [23:0] NOP  = 24'h0000AA;
  localparam logic [23:0] HALT = 24'h100000;
  localparam logic [23:0] RET  = 24'h400000;
`ifdef CPU_SEQ_RETIRE_CNT_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b11;
  logic [2:0]  speed_sel = 3'd0;
  logic        step_btn = 1'b0;
  logic        halt_in, branch_taken, call, ret;
  logic [7:0]  branch_target, imem_addr, pc;
  logic [23:0] imem_data = 24'h0, ir;
  logic        exec_en, halted, fault;
  logic [31:0] retired_count;
  logic [23:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.ADDR_W(8), .INSTR_W(24), .STACK_DEPTH(4), .SLOW_BASE_LOG2(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .speed_sel(speed_sel), .step_btn(step_btn),
    .halt_in(halt_in), .branch_taken(branch_taken), .call(call), .ret(ret),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
    .ir(ir), .exec_en(exec_en), .pc(pc), .halted(halted), .fault(fault),
    .retired_count(retired_count)
  );

  always @(posedge clk) imem_data <= mem[imem_addr];

  assign halt_in       = (ir[23:20] == 4'h1);
  assign branch_taken  = (ir[23:20] == 4'h2);
  assign call          = (ir[23:20] == 4'h3);
  assign ret           = (ir[23:20] == 4'h4);
  assign branch_target = ir[7:0];

  function automatic logic [23:0] br(input logic [7:0] t);
    return {16'h2000, t};
  endfunction
  function automatic logic [23:0] cl(input logic [7:0] t);
    return {16'h3000, t};
  endfunction
  function automatic logic [31:0] rc(input int n);
    return RC_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = NOP;
  endtask

  // Leaves the bench at the negedge where rst drops (cycle 0, state IDLE).
  task automatic do_reset(input logic [1:0] m);
    @(negedge clk);
    rst  = 1'b1;
    mode = m;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_exec(input string tag, output logic [7:0] pc_at);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!exec_en && n < 300);
    if (!exec_en) check({tag, "_timeout"}, 32'(exec_en), 32'd1);
    pc_at = pc;
  endtask

  initial begin
    logic [7:0]  p;
    logic [23:0] mask;
    int          cnt, t0, t1, t2, cyc;

    // --- reset values, then pause mode holds still ---
    clear_mem();
    do_reset(2'b11);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_ir", 32'(ir), 32'h0);
    check("rst_exec_en", 32'(exec_en), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_retired", retired_count, 32'h0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exec_en) cnt++;
    end
    check("pause_exec_count", 32'(cnt), 32'd0);

    // --- run mode: three plain instructions then HALT ---
    clear_mem();
    mem[0] = 24'h000001; mem[1] = 24'h000002; mem[2] = 24'h000003; mem[3] = HALT;
    do_reset(2'b00);
    mask = 24'h0;
    mask[0] = exec_en;
    for (int c = 1; c < 24; c++) begin
      @(negedge clk);
      mask[c] = exec_en;
      if (c == 11) check("run_ir_at_pc2", 32'(ir), 32'h000003);
    end
    check("run_exec_cycles", 32'(mask), 32'h008888);
    check("run_pc_end", 32'(pc), 32'h3);
    check("run_halted", 32'(halted), 32'h1);
    check("run_fault", 32'(fault), 32'h0);
    check("run_retired", retired_count, rc(4));

    // --- call then ret, then ret on an empty stack ---
    clear_mem();
    mem[0] = cl(8'h10); mem[8'h10] = RET; mem[1] = RET;
    do_reset(2'b00);
    wait_exec("cr_e0", p); check("cr_pc0", 32'(p), 32'h00);
    wait_exec("cr_e1", p); check("cr_pc1", 32'(p), 32'h10);
    wait_exec("cr_e2", p); check("cr_pc2", 32'(p), 32'h01);
    check("cr_fault_after_ret", 32'(fault), 32'h0);
    @(negedge clk);
    check("cr_empty_ret_fault", 32'(fault), 32'h1);
    check("cr_halted", 32'(halted), 32'h1);
    check("cr_pc_frozen", 32'(pc), 32'h01);
    check("cr_retired", retired_count, rc(2));

    // --- five nested calls overflow a 4-deep stack ---
    clear_mem();
    mem[0] = cl(8'h10); mem[8'h10] = cl(8'h20); mem[8'h20] = cl(8'h30);
    mem[8'h30] = cl(8'h40); mem[8'h40] = cl(8'h50);
    do_reset(2'b00);
    for (int k = 0; k < 5; k++) begin
      wait_exec("ov_exec", p);
      check("ov_exec_pc", 32'(p), 32'(k * 16));
    end
    @(negedge clk);
    check("ov_fault", 32'(fault), 32'h1);
    check("ov_halted", 32'(halted), 32'h1);
    check("ov_pc", 32'(pc), 32'h40);
    check("ov_retired", retired_count, rc(4));
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("ov_no_exec_in_halt", 32'(exec_en), 32'h0);

    // --- ret at pc=0 with empty stack ---
    clear_mem();
    mem[0] = RET;
    do_reset(2'b00);
    check("uf_fault_cleared", 32'(fault), 32'h0);
    wait_exec("uf_e0", p);
    @(negedge clk);
    check("uf_fault", 32'(fault), 32'h1);
    check("uf_halted", 32'(halted), 32'h1);
    check("uf_pc", 32'(pc), 32'h0);
    check("uf_retired", retired_count, rc(0));

    // --- slow mode, period 2^(2+1) = 8 ---
    clear_mem();
    speed_sel = 3'd1;
    do_reset(2'b01);
    t0 = 0; t1 = 0; t2 = 0; cnt = 0; cyc = 0;
    while (cnt < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (exec_en) begin
        if (cnt == 0) t0 = cyc;
        if (cnt == 1) t1 = cyc;
        if (cnt == 2) t2 = cyc;
        cnt++;
      end
    end
    check("slow_pulses_seen", 32'(cnt), 32'd3);
    check("slow_gap1", 32'(t1 - t0), 32'd8);
    check("slow_gap2", 32'(t2 - t1), 32'd8);

    // --- step mode: two long presses give two instructions ---
    clear_mem();
    step_btn = 1'b0;
    do_reset(2'b10);
    cnt = 0;
    for (int press = 0; press < 2; press++) begin
      step_btn = 1'b1;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (exec_en) cnt++;
      end
      step_btn = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (exec_en) cnt++;
      end
      if (press == 0) check("step_one_per_press", 32'(cnt), 32'd1);
    end
    check("step_exec_count", 32'(cnt), 32'd2);
    check("step_pc", 32'(pc), 32'h02);

    // --- pc wrap at 0xFF, then reset during LATCH ---
    clear_mem();
    mem[0] = br(8'hFF);
    do_reset(2'b00);
    wait_exec("wr_e0", p); check("wr_pc_branch", 32'(p), 32'h00);
    wait_exec("wr_e1", p); check("wr_pc_ff", 32'(p), 32'hFF);
    @(negedge clk);
    check("wr_pc_wrapped", 32'(pc), 32'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rl_exec_en", 32'(exec_en), 32'h0);
    check("rl_pc", 32'(pc), 32'h0);
    check("rl_ir", 32'(ir), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rl_exec_en_next", 32'(exec_en), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
